// File: rtl/pov_pkg.sv
// Shared constants and types for the POV display datapath.
// Room is left here for LED_COUNT and TEX_WIDTH when the texture path lands.
package pov_pkg;

  localparam int THETA_BITS = 6;
  localparam int PERIOD_W   = 28;

  typedef enum logic [1:0] {
    IDLE,
    ACQUIRE,
    RUN
  } state_t;

endpackage

// File: rtl/rotation_scheduler_if.sv
// Strip-controller handshake: refresh request, busy flag and the column index.
interface rotation_scheduler_if #(
  parameter int THETA_BITS = pov_pkg::THETA_BITS
);

  logic                  frame_start;
  logic                  frame_busy;
  logic [THETA_BITS-1:0] theta;

  modport master (output frame_start, output theta, input frame_busy);
  modport slave  (input frame_start, input theta, output frame_busy);

endinterface

// File: rtl/index_detector.sv
// Synchronises the breakbeam pin and emits one idx pulse per beam-broken onset,
// suppressed while the period counter is still inside the bounce lockout.
module index_detector #(
  parameter int PERIOD_W        = pov_pkg::PERIOD_W,
  parameter int MIN_PERIOD      = 100_000,
  parameter bit BEAM_ACTIVE_LOW = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                break_din,
  input  logic [PERIOD_W-1:0] per_cnt,
  output logic                idx
);

  // Pin level while the beam is intact; the synchroniser resets to it so
  // reset release never looks like a beam break.
  localparam logic IDLE_LEVEL = BEAM_ACTIVE_LOW;

  logic sync1, sync2, beam_d;
  logic beam;

  // NOTE: non-blocking assignments so each stage samples its neighbour's pre-edge value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= IDLE_LEVEL;
      sync2  <= IDLE_LEVEL;
      beam_d <= 1'b0;
    end else begin
      sync1  <= break_din;
      sync2  <= sync1;
      beam_d <= beam;
    end
  end

  assign beam = sync2 ^ IDLE_LEVEL;
  assign idx  = beam && !beam_d && (per_cnt >= PERIOD_W'(MIN_PERIOD));

endmodule

// File: rtl/rotation_scheduler.sv
// Measures the rotor period from index edges, slices it into 2^THETA_BITS
// angular steps and requests one strip refresh per slice.
module rotation_scheduler #(
  parameter int THETA_BITS      = pov_pkg::THETA_BITS,
  parameter int PERIOD_W        = pov_pkg::PERIOD_W,
  parameter int MIN_PERIOD      = 100_000,
  parameter int MAX_PERIOD      = 200_000_000,
  parameter bit BEAM_ACTIVE_LOW = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        break_din,
  rotation_scheduler_if.master        strip,
  output logic                        locked,
  output logic                        overrun,
  output logic [PERIOD_W-1:0]         period_out
);

  import pov_pkg::*;

  localparam logic [PERIOD_W-1:0]   MAX_CNT   = PERIOD_W'(MAX_PERIOD);
  localparam logic [PERIOD_W-1:0]   IDLE_LEN  = PERIOD_W'(MAX_PERIOD >> THETA_BITS);
  localparam logic [THETA_BITS-1:0] THETA_MAX = '1;

  state_t                state, state_nxt;
  logic [PERIOD_W-1:0]   per_cnt, per_len, slice_len, slice_end;
  logic [PERIOD_W-1:0]   slice_cnt, slice_cnt_nxt;
  logic [THETA_BITS-1:0] theta, theta_nxt;
  logic                  idx, timeout, slice_wrap, req, locked_nxt, frame_start;

  param_legal: assert property (@(posedge clk) MIN_PERIOD >= (2 ** THETA_BITS));

  index_detector #(
    .PERIOD_W        (PERIOD_W),
    .MIN_PERIOD      (MIN_PERIOD),
    .BEAM_ACTIVE_LOW (BEAM_ACTIVE_LOW)
  ) u_index (
    .clk       (clk),
    .rst_n     (rst_n),
    .break_din (break_din),
    .per_cnt   (per_cnt),
    .idx       (idx)
  );

  assign per_len    = per_cnt + 1'b1;
  assign timeout    = (per_cnt == MAX_CNT - 1'b1);
  // Before lock the slice timer free-runs on the worst-case slice length.
  assign slice_end  = (state == RUN) ? slice_len : IDLE_LEN;
  assign slice_wrap = (slice_cnt == slice_end - 1'b1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      per_cnt    <= '0;
      period_out <= '0;
      slice_len  <= '0;
    end else if (idx) begin
      per_cnt    <= '0;
      period_out <= per_len;
      slice_len  <= per_len >> THETA_BITS;
    end else if (per_cnt != MAX_CNT) begin
      per_cnt    <= per_len;
    end
  end

  // NOTE: every output gets a default first so no branch can infer a latch.
  always_comb begin
    state_nxt     = state;
    theta_nxt     = theta;
    locked_nxt    = locked;
    slice_cnt_nxt = slice_wrap ? '0 : slice_cnt + 1'b1;
    req           = 1'b0;
    unique case (state)
      IDLE: begin
        req = slice_wrap;
        if (idx) state_nxt = ACQUIRE;
      end
      ACQUIRE: begin
        if (idx) begin
          state_nxt     = RUN;
          locked_nxt    = 1'b1;
          theta_nxt     = '0;
          slice_cnt_nxt = '0;
          req           = 1'b1;
        end else if (timeout) begin
          state_nxt     = IDLE;
          slice_cnt_nxt = '0;
        end else begin
          req = slice_wrap;
        end
      end
      RUN: begin
        // Index beats a coincident slice wrap; theta sticks at the last slice.
        if (idx) begin
          theta_nxt     = '0;
          slice_cnt_nxt = '0;
          req           = 1'b1;
        end else if (timeout) begin
          state_nxt     = IDLE;
          locked_nxt    = 1'b0;
          theta_nxt     = '0;
          slice_cnt_nxt = '0;
        end else if (slice_wrap) begin
          req       = 1'b1;
          theta_nxt = (theta == THETA_MAX) ? theta : theta + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      theta       <= '0;
      slice_cnt   <= '0;
      locked      <= 1'b0;
      frame_start <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      state       <= state_nxt;
      theta       <= theta_nxt;
      slice_cnt   <= slice_cnt_nxt;
      locked      <= locked_nxt;
      frame_start <= req && !strip.frame_busy;
      overrun     <= overrun || (req && strip.frame_busy);
    end
  end

  assign strip.frame_start = frame_start;
  assign strip.theta       = theta;

endmodule

// File: tb/tb_rotation_scheduler.sv
// Scoreboard bench for rotation_scheduler with a cycle-time reference model.
module tb_rotation_scheduler;

  localparam int TB       = 2;
  localparam int PW       = 28;
  localparam int MINP     = 16;
  localparam int MAXP     = 1000;
  localparam int IDLE_LEN = MAXP >> TB;
  localparam int TMAX     = (1 << TB) - 1;
  localparam int M_IDLE = 0, M_ACQ = 1, M_RUN = 2;

  typedef struct {
    longint cyc;
    int     theta;
  } fs_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          break_din;
  logic          locked, overrun;
  logic [PW-1:0] period_out;

  rotation_scheduler_if #(.THETA_BITS(TB)) bus ();

  rotation_scheduler #(
    .THETA_BITS(TB), .PERIOD_W(PW), .MIN_PERIOD(MINP),
    .MAX_PERIOD(MAXP), .BEAM_ACTIVE_LOW(1'b1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .break_din  (break_din),
    .strip      (bus),
    .locked     (locked),
    .overrun    (overrun),
    .period_out (period_out)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: everything is expressed in clock-edge numbers. A beam
  // break sampled at edge k acts at edge k+2; revolutions, slices and
  // timeouts are differences of edge numbers.
  longint cyc = 0;
  longint last_acc, idle_start, run_start, m_len;
  longint onset_q[$];
  fs_t    exp_q[$];
  int     m_mode, e_theta;
  bit     e_locked, e_overrun, prev_pin;
  longint e_period;

  task automatic model_step(bit pin, bit busy);
    bit     acc, push;
    longint e, per;
    if (prev_pin && !pin) onset_q.push_back(cyc + 2);
    prev_pin = pin;
    acc  = 1'b0;
    push = 1'b0;
    if (onset_q.size() > 0 && onset_q[0] == cyc) begin
      void'(onset_q.pop_front());
      acc = (cyc - last_acc - 1) >= MINP;
    end
    if (acc) begin
      per      = cyc - last_acc;
      e_period = (per > MAXP + 1) ? MAXP + 1 : per;
      last_acc = cyc;
    end
    if (m_mode == M_IDLE) begin
      push = ((cyc - idle_start) % IDLE_LEN) == 0;
      if (acc) m_mode = M_ACQ;
    end else if (acc) begin
      m_mode    = M_RUN;
      e_locked  = 1'b1;
      m_len     = e_period >> TB;
      run_start = cyc;
      e_theta   = 0;
      push      = 1'b1;
    end else if (cyc - last_acc == MAXP) begin
      m_mode     = M_IDLE;
      e_locked   = 1'b0;
      e_theta    = 0;
      idle_start = cyc;
    end else if (m_mode == M_RUN) begin
      e = cyc - run_start;
      if (e % m_len == 0) begin
        push    = 1'b1;
        e_theta = (e / m_len > TMAX) ? TMAX : int'(e / m_len);
      end
    end else begin
      push = ((cyc - idle_start) % IDLE_LEN) == 0;
    end
    if (push) begin
      if (busy) e_overrun = 1'b1;
      else      exp_q.push_back('{cyc, e_theta});
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
    if (!rst_n) begin
      m_mode     = M_IDLE;
      last_acc   = cyc;
      idle_start = cyc;
      run_start  = cyc;
      m_len      = 1;
      e_theta    = 0;
      e_locked   = 1'b0;
      e_overrun  = 1'b0;
      e_period   = 0;
      prev_pin   = 1'b1;
      onset_q.delete();
      exp_q.delete();
    end else begin
      model_step(break_din, bus.frame_busy);
    end
  end

  // Monitor: compares live outputs each cycle and pops the scoreboard on refreshes.
  fs_t f;
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      check("theta", 64'(bus.theta), 64'(e_theta));
      check("locked", 64'(locked), 64'(e_locked));
      check("overrun", 64'(overrun), 64'(e_overrun));
      check("period_out", 64'(period_out), 64'(e_period));
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        f = exp_q.pop_front();
        check("frame_start_expected", 64'(bus.frame_start), 64'd1);
        check("theta_at_frame_start", 64'(bus.theta), 64'(f.theta));
      end else begin
        check("frame_start_quiet", 64'(bus.frame_start), 64'd0);
      end
    end
  end

  // One revolution: beam broken for 3 cycles, optional 2-cycle glitch, optional busy window.
  task automatic rev(int period, int glitch_at = -1, int busy_from = -1, int busy_len = 0);
    for (int i = 0; i < period; i++) begin
      break_din = !((i < 3) || (glitch_at >= 0 && i >= glitch_at && i < glitch_at + 2));
      bus.frame_busy = (i >= busy_from) && (i < busy_from + busy_len);
      @(negedge clk);
    end
    break_din      = 1'b1;
    bus.frame_busy = 1'b0;
  endtask

  task automatic check_all_zero(string tag);
    check({tag, "_theta"}, 64'(bus.theta), 64'd0);
    check({tag, "_frame_start"}, 64'(bus.frame_start), 64'd0);
    check({tag, "_locked"}, 64'(locked), 64'd0);
    check({tag, "_overrun"}, 64'(overrun), 64'd0);
    check({tag, "_period_out"}, 64'(period_out), 64'd0);
  endtask

  initial begin
    int p, g, bf, bl;
    rst_n          = 1'b0;
    break_din      = 1'b1;
    bus.frame_busy = 1'b0;
    #1 check_all_zero("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Free run with no index.
    repeat (600) @(negedge clk);
    check("freerun_locked", 64'(locked), 64'd0);

    // Lock at 400, then a bounce glitch that must be ignored.
    rev(400);
    rev(400);
    check("lock_locked", 64'(locked), 64'd1);
    check("lock_period", 64'(period_out), 64'd400);
    check("lock_theta_last_slice", 64'(bus.theta), 64'd3);
    rev(400, 5);
    rev(400);
    check("bounce_period", 64'(period_out), 64'd400);

    // Slowdown to 600: theta parks at 3, next revolution uses 150-cycle slices.
    rev(600);
    check("slow_theta_hold", 64'(bus.theta), 64'd3);
    rev(600);
    check("slow_period", 64'(period_out), 64'd600);

    // Busy across the first slice boundary.
    rev(600, -1, 140, 20);
    check("busy_overrun", 64'(overrun), 64'd1);
    rev(600);
    check("busy_overrun_sticky", 64'(overrun), 64'd1);

    // Loss of sync.
    repeat (1200) @(negedge clk);
    check("lost_locked", 64'(locked), 64'd0);
    check("lost_theta", 64'(bus.theta), 64'd0);

    // Relock and probe the lockout boundary: 17 accepted, 16 rejected.
    rev(400);
    rev(400);
    rev(17);
    rev(16);
    check("lockout_17_accepted", 64'(period_out), 64'd17);
    rev(17);
    rev(400);
    check("lockout_16_rejected", 64'(period_out), 64'd33);
    rev(400);

    // Asynchronous reset mid-count.
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check_all_zero("midreset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (300) @(negedge clk);

    // Randomised revolutions with glitches, busy windows and occasional timeouts.
    for (int n = 0; n < 24; n++) begin
      p  = $urandom_range(20, 1100);
      g  = ($urandom_range(0, 3) == 0) ? $urandom_range(4, (p - 3 < 30) ? p - 3 : 30) : -1;
      bf = ($urandom_range(0, 2) == 0) ? $urandom_range(0, p - 1) : -1;
      bl = $urandom_range(1, 40);
      rev(p, g, bf, bl);
    end
    repeat (300) @(negedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
